// File: rtl/free_list_3a_3f.sv
// -----------------------------------------------------------------------------
// free_list_3a_3f
//   Physical-register free list for a 3-wide rename / 3-wide retire core.
//   Tags live in a circular buffer of ARRAY_ENTRY slots. Allocation reads up to
//   three consecutive slots from the head; release writes up to three
//   consecutive slots at the tail. Allocation is all-or-nothing against the
//   registered count, and released tags only become visible the cycle after.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   allocN_req_i              allocation request from rename slot N (1..3)
//   allocN_tag_o              tag offered to rename slot N (combinational)
//   alloc_ok_o                whole request set can be granted this cycle
//   freeN_en_i, freeN_tag_i   tag release strobe / tag from retire slot N
//   count_o                   registered number of free tags
//   empty_o                   count_o == 0
//   overflow_err_o            sticky: a release was dropped because list full
// -----------------------------------------------------------------------------
module free_list_3a_3f #(
  parameter int ARRAY_ENTRY   = 32,
  parameter int REGNAME_WIDTH = 5,
  parameter int RESET_COUNT   = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alloc1_req_i,
  input  logic                     alloc2_req_i,
  input  logic                     alloc3_req_i,
  output logic [REGNAME_WIDTH-1:0] alloc1_tag_o,
  output logic [REGNAME_WIDTH-1:0] alloc2_tag_o,
  output logic [REGNAME_WIDTH-1:0] alloc3_tag_o,
  output logic                     alloc_ok_o,
  input  logic                     free1_en_i,
  input  logic                     free2_en_i,
  input  logic                     free3_en_i,
  input  logic [REGNAME_WIDTH-1:0] free1_tag_i,
  input  logic [REGNAME_WIDTH-1:0] free2_tag_i,
  input  logic [REGNAME_WIDTH-1:0] free3_tag_i,
  output logic [REGNAME_WIDTH:0]   count_o,
  output logic                     empty_o,
  output logic                     overflow_err_o
);

  localparam int CW = REGNAME_WIDTH + 1;
  // One extra bit so count + frees never wraps before the full check.
  localparam logic [CW:0] AE_L = (CW+1)'(ARRAY_ENTRY);

  // State
  logic [REGNAME_WIDTH-1:0] r_slot [ARRAY_ENTRY];
  logic [REGNAME_WIDTH-1:0] r_head;
  logic [REGNAME_WIDTH-1:0] r_tail;
  logic [CW-1:0]            r_count;
  logic                     r_ovf;

  // Per-port views of the request / release inputs
  logic [2:0]               w_req;
  logic [2:0]               w_free_en;
  logic [REGNAME_WIDTH-1:0] w_free_tag [3];
  logic [REGNAME_WIDTH-1:0] w_alloc_tag [3];

  assign w_req         = {alloc3_req_i, alloc2_req_i, alloc1_req_i};
  assign w_free_en     = {free3_en_i, free2_en_i, free1_en_i};
  assign w_free_tag[0] = free1_tag_i;
  assign w_free_tag[1] = free2_tag_i;
  assign w_free_tag[2] = free3_tag_i;

  // ---------------------------------------------------------------------------
  // Allocation side
  // ---------------------------------------------------------------------------
  logic [1:0] w_req_n;
  logic [1:0] w_grant_n;
  logic       w_alloc_ok;
  logic [1:0] w_rd_off [3];

  always_comb begin
    w_req_n = 2'(w_req[0]) + 2'(w_req[1]) + 2'(w_req[2]);
  end

  // Grant decision uses the registered count only, never this cycle's frees.
  assign w_alloc_ok = (r_count >= CW'(w_req_n));
  assign w_grant_n  = w_alloc_ok ? w_req_n : 2'd0;

  // A requesting port takes the slot after all lower requesting ports.
  // An idle port shows slot[head + its own position], which keeps the
  // idle outputs a simple preview of the next three free tags.
  always_comb begin
    w_rd_off[0] = 2'd0;
    w_rd_off[1] = w_req[1] ? 2'(w_req[0]) : 2'd1;
    w_rd_off[2] = w_req[2] ? (2'(w_req[0]) + 2'(w_req[1])) : 2'd2;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_rd
      assign w_alloc_tag[gi] = r_slot[r_head + REGNAME_WIDTH'(w_rd_off[gi])];
    end
  endgenerate

  assign alloc1_tag_o = w_alloc_tag[0];
  assign alloc2_tag_o = w_alloc_tag[1];
  assign alloc3_tag_o = w_alloc_tag[2];
  assign alloc_ok_o   = w_alloc_ok;

  // ---------------------------------------------------------------------------
  // Release side: accept frees in port order while the list has room after
  // this cycle's grant; anything beyond that is dropped and flagged.
  // ---------------------------------------------------------------------------
  logic [CW:0]  w_level;
  logic [2:0]   w_acc;
  logic [1:0]   w_nacc;
  logic         w_drop;
  logic [1:0]   w_wr_off [3];
  logic [CW-1:0] w_count_next;

  always_comb begin
    w_level = (CW+1)'(r_count) - (CW+1)'(w_grant_n);
    w_acc   = 3'b000;
    w_nacc  = 2'd0;
    w_drop  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      w_wr_off[k] = w_nacc;
      if (w_free_en[k]) begin
        if (w_level < AE_L) begin
          w_acc[k] = 1'b1;
          w_level  = w_level + 1'b1;
          w_nacc   = w_nacc + 2'd1;
        end else begin
          w_drop = 1'b1;
        end
      end
    end
    w_count_next = CW'(w_level);
  end

  // ---------------------------------------------------------------------------
  // State update
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      // Free tags occupy slots 0..RESET_COUNT-1; the rest hold the tags
      // currently in architectural use, so the ring stays a permutation.
      for (int i = 0; i < ARRAY_ENTRY; i++) begin
        r_slot[i] <= REGNAME_WIDTH'((i + ARRAY_ENTRY - RESET_COUNT) % ARRAY_ENTRY);
      end
      r_head  <= '0;
      r_tail  <= REGNAME_WIDTH'(RESET_COUNT % ARRAY_ENTRY);
      r_count <= CW'(RESET_COUNT);
      r_ovf   <= 1'b0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (w_acc[k]) begin
          r_slot[r_tail + REGNAME_WIDTH'(w_wr_off[k])] <= w_free_tag[k];
        end
      end
      r_head  <= r_head + REGNAME_WIDTH'(w_grant_n);
      r_tail  <= r_tail + REGNAME_WIDTH'(w_nacc);
      r_count <= w_count_next;
      r_ovf   <= r_ovf | w_drop;
    end
  end

  assign count_o        = r_count;
  assign empty_o        = (r_count == '0);
  assign overflow_err_o = r_ovf;

endmodule

// File: tb/tb_free_list_3a_3f.sv
// -----------------------------------------------------------------------------
// tb_free_list_3a_3f
//   Self-checking bench for free_list_3a_3f. A queue of free tags models the
//   list: allocation pops from the front, release pushes to the back while
//   fewer than 32 tags are held. Every cycle the DUT outputs are compared with
//   the queue; directed scenarios add literal expectations on top.
// -----------------------------------------------------------------------------
module tb_free_list_3a_3f;

  localparam int AE = 32;
  localparam int W  = 5;
  localparam int RC = 24;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         r1 = 0, r2 = 0, r3 = 0;
  logic         f1 = 0, f2 = 0, f3 = 0;
  logic [W-1:0] ft1 = '0, ft2 = '0, ft3 = '0;
  logic [W-1:0] t1, t2, t3;
  logic         ok;
  logic [W:0]   cnt;
  logic         empty, ovf;

  free_list_3a_3f #(.ARRAY_ENTRY(AE), .REGNAME_WIDTH(W), .RESET_COUNT(RC)) dut (
    .clk(clk), .rst(rst),
    .alloc1_req_i(r1), .alloc2_req_i(r2), .alloc3_req_i(r3),
    .alloc1_tag_o(t1), .alloc2_tag_o(t2), .alloc3_tag_o(t3),
    .alloc_ok_o(ok),
    .free1_en_i(f1), .free2_en_i(f2), .free3_en_i(f3),
    .free1_tag_i(ft1), .free2_tag_i(ft2), .free3_tag_i(ft3),
    .count_o(cnt), .empty_o(empty), .overflow_err_o(ovf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int q[$];
  bit m_ovf   = 0;
  bit m_valid = 0;
  int mn;

  function automatic void m_free(input int tag);
    if (q.size() < AE) q.push_back(tag);
    else m_ovf = 1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      for (int i = 0; i < RC; i++) q.push_back((i + AE - RC) % AE);
      m_ovf   = 0;
      m_valid = 1;
    end else if (m_valid) begin
      mn = int'(r1) + int'(r2) + int'(r3);
      if (q.size() >= mn) repeat (mn) void'(q.pop_front());
      if (f1) m_free(int'(ft1));
      if (f2) m_free(int'(ft2));
      if (f3) m_free(int'(ft3));
    end
  end

  // ---------------- per-cycle compare ----------------
  int cn, cj;
  bit c_ok;
  always @(negedge clk) begin
    if (m_valid) begin
      cn   = int'(r1) + int'(r2) + int'(r3);
      c_ok = (q.size() >= cn);
      $display("t=%0t rst=%b req=%b%b%b free=%b%b%b ok=%b tags=%0d/%0d/%0d cnt=%0d ovf=%b",
               $time, rst, r1, r2, r3, f1, f2, f3, ok, t1, t2, t3, cnt, ovf);
      chk("count", int'(cnt), q.size());
      chk("empty", int'(empty), int'(q.size() == 0));
      chk("overflow", int'(ovf), int'(m_ovf));
      chk("alloc_ok", int'(ok), int'(c_ok));
      if (c_ok) begin
        cj = 0;
        if (r1) begin chk("tag1", int'(t1), q[cj]); cj++; end
        if (r2) begin chk("tag2", int'(t2), q[cj]); cj++; end
        if (r3) begin chk("tag3", int'(t3), q[cj]); cj++; end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit a, input bit b, input bit c);
    r1 = a; r2 = b; r3 = c;
  endtask

  task automatic set_free(input bit a, input bit b, input bit c,
                          input int ta, input int tb, input int tc);
    f1 = a; f2 = b; f3 = c;
    ft1 = W'(ta); ft2 = W'(tb); ft3 = W'(tc);
  endtask

  task automatic do_reset();
    rst = 1; tick(); rst = 0;
  endtask

  initial begin
    set_req(0, 0, 0);
    set_free(0, 0, 0, 0, 0, 0);
    tick(); tick();
    rst = 0;

    // Reset state with idle ports
    #1;
    chk("rst_tag1", int'(t1), 8);
    chk("rst_tag2", int'(t2), 9);
    chk("rst_tag3", int'(t3), 10);
    chk("rst_count", int'(cnt), 24);
    chk("rst_empty", int'(empty), 0);
    chk("rst_ovf", int'(ovf), 0);

    // Three requests after reset
    set_req(1, 1, 1); #1;
    chk("a3_ok", int'(ok), 1);
    chk("a3_tag1", int'(t1), 8);
    chk("a3_tag2", int'(t2), 9);
    chk("a3_tag3", int'(t3), 10);
    tick(); #1;
    chk("a3_count", int'(cnt), 21);
    chk("a3n_tag1", int'(t1), 11);
    chk("a3n_tag2", int'(t2), 12);
    chk("a3n_tag3", int'(t3), 13);
    set_req(0, 0, 0);
    tick();

    // Ports 1 and 3 only
    do_reset();
    set_req(1, 0, 1); #1;
    chk("p13_tag1", int'(t1), 8);
    chk("p13_tag3", int'(t3), 9);
    tick();
    set_req(1, 0, 0); #1;
    chk("p13_count", int'(cnt), 22);
    chk("p13_next_tag1", int'(t1), 10);
    set_req(0, 0, 0);
    tick();

    // Drain to 2, refused 3-request with simultaneous frees
    do_reset();
    set_req(1, 1, 1);
    repeat (7) tick();
    set_req(1, 0, 0);
    tick();
    set_req(1, 1, 1);
    set_free(1, 1, 0, 8, 9, 0); #1;
    chk("short_count", int'(cnt), 2);
    chk("short_ok", int'(ok), 0);
    tick();
    set_free(0, 0, 0, 0, 0, 0); #1;
    chk("short_count_next", int'(cnt), 4);
    chk("short_ok_next", int'(ok), 1);
    chk("short_tag1", int'(t1), 30);
    chk("short_tag2", int'(t2), 31);
    chk("short_tag3", int'(t3), 8);
    tick();
    set_req(0, 0, 0);
    tick();

    // Frees across the tail wrap (tail 30 -> 1)
    do_reset();
    set_req(1, 1, 1);
    repeat (3) tick();
    set_req(0, 0, 0);
    set_free(1, 1, 0, 0, 1, 0); tick();
    set_free(1, 1, 0, 2, 3, 0); tick();
    set_free(1, 1, 0, 4, 5, 0); tick();
    set_free(1, 1, 1, 20, 21, 22); tick();
    set_free(0, 0, 0, 0, 0, 0);
    set_req(1, 1, 1);
    repeat (7) tick();
    #1;
    chk("wrap_count", int'(cnt), 3);
    chk("wrap_tag1", int'(t1), 20);
    chk("wrap_tag2", int'(t2), 21);
    chk("wrap_tag3", int'(t3), 22);
    tick();
    set_req(0, 0, 0);
    tick();

    // Overflow at count 31
    do_reset();
    set_free(1, 1, 1, 0, 1, 2); tick();
    set_free(1, 1, 1, 3, 4, 5); tick();
    set_free(1, 0, 0, 6, 0, 0); tick();
    #1;
    chk("ovf_pre_count", int'(cnt), 31);
    set_free(1, 1, 1, 7, 7, 7); tick();
    set_free(0, 0, 0, 0, 0, 0); #1;
    chk("ovf_count", int'(cnt), 32);
    chk("ovf_flag", int'(ovf), 1);
    set_req(1, 1, 1);
    repeat (3) tick();
    #1;
    chk("ovf_sticky", int'(ovf), 1);

    // Reset mid-stream with allocs and frees active
    set_free(1, 1, 1, 3, 4, 5);
    rst = 1; tick(); rst = 0;
    set_free(0, 0, 0, 0, 0, 0);
    set_req(0, 0, 0); #1;
    chk("mid_rst_count", int'(cnt), 24);
    chk("mid_rst_tag1", int'(t1), 8);
    chk("mid_rst_tag2", int'(t2), 9);
    chk("mid_rst_tag3", int'(t3), 10);
    chk("mid_rst_ovf", int'(ovf), 0);
    tick();

    // Random traffic against the model
    for (int c = 0; c < 1500; c++) begin
      int r;
      r = int'($urandom);
      set_req(r[0], r[1], r[2]);
      set_free(r[3], r[4], r[5],
               int'($urandom_range(0, AE - 1)),
               int'($urandom_range(0, AE - 1)),
               int'($urandom_range(0, AE - 1)));
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 0;
    set_req(0, 0, 0);
    set_free(0, 0, 0, 0, 0, 0);
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/free_list_3a_3f.md
FREE_LIST_3A_3F -- requirements
Module: free_list_3a_3f

Interface
REQ-001 SHALL have parameter ARRAY_ENTRY, default 32, giving the number of physical register tags managed and the list depth.
REQ-002 SHALL have parameter REGNAME_WIDTH, default 5, giving the tag width; ARRAY_ENTRY == 2**REGNAME_WIDTH.
REQ-003 SHALL have parameter RESET_COUNT, default 24, giving the number of free tags after reset; range 0..ARRAY_ENTRY.
REQ-004 SHALL have `clk` input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have `rst` input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have `alloc1_req_i`, `alloc2_req_i`, `alloc3_req_i` inputs, 1 bit each: allocation requests from rename slots 1..3.
REQ-007 SHALL have `alloc1_tag_o`, `alloc2_tag_o`, `alloc3_tag_o` outputs, REGNAME_WIDTH each: tags offered to the requesting slots, feeding the write addresses of the 3r/3w valid/data RAM.
REQ-008 SHALL have `alloc_ok_o` output, 1 bit: the current request set is granted in full this cycle.
REQ-009 SHALL have `free1_en_i`, `free2_en_i`, `free3_en_i` inputs, 1 bit each: tag release strobes from retire slots 1..3.
REQ-010 SHALL have `free1_tag_i`, `free2_tag_i`, `free3_tag_i` inputs, REGNAME_WIDTH each: the released tags.
REQ-011 SHALL have `count_o` output, REGNAME_WIDTH+1 bits: registered number of free tags.
REQ-012 SHALL have `empty_o` output, 1 bit: count_o == 0.
REQ-013 SHALL have `overflow_err_o` output, 1 bit: sticky release-overflow error.

Function
REQ-014 SHALL store tags in an ARRAY_ENTRY-slot circular buffer with a head (read) pointer, a tail (write) pointer and a count register; both pointers SHALL wrap modulo ARRAY_ENTRY.
REQ-015 SHALL let N = number of asserted alloc requests (0..3) and drive alloc_ok_o = (count >= N), combinationally from the registered count only.
REQ-016 SHALL assign tags to asserted requests in port order: the lowest asserted port gets slot[head], the next gets slot[head+1], the third gets slot[head+2] (all indices modulo ARRAY_ENTRY).
REQ-017 SHALL drive an unrequested port's tag output with that port's would-be slot value; it is don't-care to consumers.
REQ-018 SHALL make tag outputs zero-latency: combinational reads of registered state, valid in the same cycle as the request.
REQ-019 SHALL, on a clock edge with alloc_ok_o=1, advance head by N; with alloc_ok_o=0, grant nothing, leave head unchanged, and leave the requester to re-present next cycle (all-or-nothing).
REQ-020 SHALL, for released tags, write the asserted free ports in port order to slot[tail], slot[tail+1], slot[tail+2] and advance tail by the number accepted.
REQ-021 SHALL give the next count as count - granted + accepted frees.
REQ-022 SHALL NOT make tags released in cycle t available to allocation until cycle t+1 (no bypass).
REQ-023 SHALL, when simultaneous alloc and free are present, evaluate the grant against the pre-edge count, so a full grant and all frees may both occur in one edge.
REQ-024 SHALL accept a free only while (count - granted + frees accepted so far) < ARRAY_ENTRY, dropping later frees in port order.
REQ-025 SHALL set overflow_err_o on any dropped free and hold it at 1 until rst.
REQ-026 SHALL NOT check released tags for duplicates.

Reset
REQ-027 SHALL, at a rising edge with rst=1, load slot i with (i + ARRAY_ENTRY - RESET_COUNT) mod ARRAY_ENTRY, set head=0, tail=RESET_COUNT mod ARRAY_ENTRY, count_o=RESET_COUNT and overflow_err_o=0.
REQ-028 SHALL, with defaults after reset, show alloc1/2/3_tag_o = 8/9/10, count_o=24, empty_o=0.
REQ-029 SHALL let rst override all same-cycle allocs and frees, including one asserted mid-operation; the next cycle's state is exactly the reset state.

Verification
REQ-030 SHALL be covered by: reset, all 3 alloc requests -> alloc_ok_o=1, tags 8,9,10; next cycle count_o=21 and tags 11,12,13.
REQ-031 SHALL be covered by: after reset, requests on ports 1 and 3 only -> port1 tag=8, port3 tag=9; next cycle count_o=22 and alloc1_tag_o=10.
REQ-032 SHALL be covered by: drain to count_o=2, request 3 while freeing tags 8 and 9 -> alloc_ok_o=0, head unchanged; next cycle count_o=4 and a 3-request is granted.
REQ-033 SHALL be covered by: 3 frees with tail at 30 -> writes to slots 30,31,0, tail=1; later allocations return the freed tags in order across the wrap.
REQ-034 SHALL be covered by: count_o=31, free 3 tags, no alloc -> first free accepted, count_o=32, others dropped, overflow_err_o=1 and held until rst.
REQ-035 SHALL be covered by: rst asserted mid-stream with allocs and frees active -> next cycle count_o=24, tags 8,9,10, overflow_err_o=0.
